// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: port A (ALU result) and port B (load data). Requests are
// arbitrated round-robin with valid/ready handshakes. The regfile-facing
// write enable, index and data are all driven from registers, so a transfer
// accepted at edge N is presented to the regfile during cycle N..N+1.
// Writes to register 0 complete their handshake but are dropped, so the
// write enable stays low for them.
//
// Optional feature (compile-time macro REGFILE_ARB_FILL_EN):
//   A fill engine that sweeps registers 1..2^ADDR_WIDTH-1 with a constant
//   value latched at start, one write per cycle. Without the macro the fill
//   ports remain on the module: fill_start/fill_value are ignored and
//   fill_busy is tied low.
//
// Ports:
//   clock           in   single clock, all state updates on posedge
//   ctrl_reset      in   synchronous, active-high reset
//   a_valid/b_valid in   write request from port A / port B
//   a_ready/b_ready out  request accepted this cycle (combinational)
//   a_reg/b_reg     in   destination register index
//   a_data/b_data   in   write data
//   ctrl_writeEn    out  regfile write enable (registered)
//   ctrl_writeReg   out  regfile write index (registered)
//   data_writeReg   out  regfile write data (registered)
//   contention_cnt  out  saturating count of cycles with both valids high
//   fill_start      in   start a fill sweep (fill build only)
//   fill_value      in   fill data, sampled on start (fill build only)
//   fill_busy       out  fill sweep in progress (fill build only)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_reg,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_reg,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  ctrl_writeEn,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [CNT_WIDTH-1:0]  contention_cnt,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy
);

`ifdef REGFILE_ARB_FILL_EN
  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  state_t state;
  logic   prioA;      // 1: port A wins the next contended cycle
  logic   fillReq;    // fill start request seen in IDLE
  logic   grantA;
  logic   grantB;

`ifdef REGFILE_ARB_FILL_EN
  logic [ADDR_WIDTH-1:0] fillIdx;
  logic [DATA_WIDTH-1:0] fillData;

  assign fillReq   = fill_start;
  assign fill_busy = (state == FILL);
`else
  // Fill ports exist for interface compatibility only in this build.
  logic unusedFill;
  assign unusedFill = fill_start ^ (^fill_value);
  assign fillReq    = 1'b0;
  assign fill_busy  = 1'b0;
`endif

  // Grant decision. A pending fill start takes the cycle, so neither port is
  // granted on the edge that enters FILL.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grantA = 1'b0;
    grantB = 1'b0;
    if (!ctrl_reset && state == IDLE && !fillReq) begin
      if (a_valid && (!b_valid || prioA)) begin
        grantA = 1'b1;
      end else if (b_valid) begin
        grantB = 1'b1;
      end
    end
  end

  assign a_ready = grantA;
  assign b_ready = grantB;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      // NOTE: only control state and the regfile-facing registers are reset;
      // the fill data latch is reset as well since it is a single register,
      // not a memory, and this keeps its value deterministic.
      state          <= IDLE;
      prioA          <= 1'b1;
      ctrl_writeEn   <= 1'b0;
      ctrl_writeReg  <= '0;
      data_writeReg  <= '0;
      contention_cnt <= '0;
`ifdef REGFILE_ARB_FILL_EN
      fillIdx        <= '0;
      fillData       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // pre-edge values regardless of statement order.
      if (a_valid && b_valid && contention_cnt != '1) begin
        contention_cnt <= contention_cnt + 1'b1;
      end

      // Write enable is a one-cycle pulse; index and data hold otherwise.
      ctrl_writeEn <= 1'b0;

      if (state == IDLE) begin
`ifdef REGFILE_ARB_FILL_EN
        if (fillReq) begin
          state    <= FILL;
          fillIdx  <= ADDR_WIDTH'(1);
          fillData <= fill_value;
        end else
`endif
        if (grantA) begin
          ctrl_writeEn  <= (a_reg != '0);
          ctrl_writeReg <= a_reg;
          data_writeReg <= a_data;
          prioA         <= 1'b0;
        end else if (grantB) begin
          ctrl_writeEn  <= (b_reg != '0);
          ctrl_writeReg <= b_reg;
          data_writeReg <= b_data;
          prioA         <= 1'b1;
        end
      end
`ifdef REGFILE_ARB_FILL_EN
      else begin
        // FILL: one register per cycle; the edge presenting the last index
        // also returns to IDLE, so requests are grantable the cycle after.
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= fillIdx;
        data_writeReg <= fillData;
        fillIdx       <= fillIdx + 1'b1;
        if (fillIdx == '1) begin
          state <= IDLE;
        end
      end
`endif
    end
  end

endmodule
